// File: rtl/irq_sched_pkg.sv
// ============================================================================
//  Module   : irq_sched_pkg
//  Purpose  : Shared state encoding, interrupt cause codes and the bundled
//             in/out structs for the machine-mode interrupt scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package irq_sched_pkg;

  // Scheduler state: one request outstanding at a time, tracked until mret
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    HOLD    = 2'd3
  } irq_state_type;

  // Interrupt cause codes (low byte of mcause)
  localparam logic [7:0] interrupt_mach_soft   = 8'd3;
  localparam logic [7:0] interrupt_mach_timer  = 8'd7;
  localparam logic [7:0] interrupt_mach_extern = 8'd11;
  localparam logic [7:0] interrupt_uart_extern = 8'd16;

  // Upper 24 bits of every interrupt cause: interrupt flag set, rest zero
  localparam logic [23:0] IRQ_CAUSE_PREFIX = {1'b1, 23'b0};

  // Raw inputs as seen by the CSR unit binding
  typedef struct packed {
    logic       meip;
    logic       msip;
    logic       mtip;
    logic       irpt;
    logic       mstatus_mie;
    logic [2:0] mie_en;
    logic       valid;
    logic       trap_ack;
    logic       mret;
  } irq_sched_in_type;

  // Outputs towards the CSR trap-entry logic
  typedef struct packed {
    logic        irq_req;
    logic [31:0] irq_cause;
    logic [3:0]  irq_pend;
    logic        busy;
  } irq_sched_out_type;

  // Build a full 32-bit interrupt cause from an 8-bit code
  function automatic logic [31:0] irq_make_cause(input logic [7:0] code);
    return {IRQ_CAUSE_PREFIX, code};
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
//  Module   : irq_prio_enc
//  Purpose  : Combinational 4-to-1 priority encoder. Bit 0 is the highest
//             priority source (meip), bit 3 the lowest (UART).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_prio_enc
  import irq_sched_pkg::*;
(
  input  logic       gie,       // global interrupt enable
  input  logic [3:0] pend,      // {irpt_p, mtip, msip, meip}
  input  logic [3:0] en,        // per-source enables, same bit order
  output logic       eligible,  // at least one enabled source pending
  output logic [7:0] code       // cause code of the winning source
);

  logic [3:0] elig;

  // Mask sources with their enables and pick the highest-priority one
  always_comb begin
    elig     = pend & en;
    eligible = gie & (|elig);
    code     = 8'd0;
    if (elig[0]) begin
      code = interrupt_mach_extern;
    end else if (elig[1]) begin
      code = interrupt_mach_soft;
    end else if (elig[2]) begin
      code = interrupt_mach_timer;
    end else if (elig[3]) begin
      code = interrupt_uart_extern;
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_sched.sv
// ============================================================================
//  Module   : irq_sched
//  Purpose  : Machine-mode interrupt scheduler in front of the CSR unit.
//             Arbitrates enabled sources, issues one request at a time with
//             a stable cause, tracks the handler until mret and applies a
//             programmable hold-off before arbitrating again.
//  Options  : IRQ_SCHED_IRPT_EDGE_EN - irpt becomes edge-detected and sticky.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int HOLDOFF = 2,   // cycles in HOLD after mret
  parameter int CNT_W   = 4    // hold-off counter width, HOLDOFF < 2**CNT_W
) (
  input  logic        clock,
  input  logic        reset,        // synchronous, active-low
  input  logic        meip,
  input  logic        msip,
  input  logic        mtip,
  input  logic        irpt,
  input  logic        mstatus_mie,
  input  logic [2:0]  mie_en,       // {meie, msie, mtie}
  input  logic        valid,
  input  logic        trap_ack,
  input  logic        mret,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic [3:0]  irq_pend,
  output logic        busy
);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  irq_state_type state_q, state_d;
  logic              irq_req_q, irq_req_d;
  logic [31:0]       irq_cause_q, irq_cause_d;
  logic [3:0]        irq_pend_q, irq_pend_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Enable aliases
  logic meie, msie, mtie;
  assign meie = mie_en[2];
  assign msie = mie_en[1];
  assign mtie = mie_en[0];

  // --------------------------------------------------------------------------
  // UART source conditioning
  // --------------------------------------------------------------------------
  logic irpt_p;       // pending view of the UART source
  logic uart_sticky;  // a latched UART request may not be withdrawn

`ifdef IRQ_SCHED_IRPT_EDGE_EN
  logic irpt_prev_q, irpt_prev_d;
  logic irpt_p_q, irpt_p_d;
  logic irpt_rise;
  logic irpt_clr;

  // Rising-edge detect sets the sticky flag; an ack for the UART request
  // clears it, but a new edge in the same cycle wins over the clear.
  always_comb begin
    irpt_prev_d = irpt;
    irpt_rise   = irpt & ~irpt_prev_q;
    irpt_clr    = trap_ack & (state_q == REQ) &
                  (irq_cause_q[7:0] == interrupt_uart_extern);
    irpt_p_d    = irpt_rise | (irpt_p_q & ~irpt_clr);
  end

  // Edge-detect and sticky-pending registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      irpt_prev_q <= 1'b0;
      irpt_p_q    <= 1'b0;
    end else begin
      irpt_prev_q <= irpt_prev_d;
      irpt_p_q    <= irpt_p_d;
    end
  end

  assign irpt_p      = irpt_p_q;
  assign uart_sticky = 1'b1;
`else
  assign irpt_p      = irpt;
  assign uart_sticky = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Priority encoding
  // --------------------------------------------------------------------------
  logic [3:0] src_pend;
  logic [3:0] src_en;
  logic       eligible_any;
  logic [7:0] enc_code;

  assign src_pend = {irpt_p, mtip, msip, meip};
  assign src_en   = {meie, mtie, msie, meie};   // irpt is gated by meie

  irq_prio_enc u_prio_enc (
    .gie      (mstatus_mie),
    .pend     (src_pend),
    .en       (src_en),
    .eligible (eligible_any),
    .code     (enc_code)
  );

  // Is the source behind the outstanding request still eligible?
  logic latched_elig;

  // Re-evaluate only the latched source; a higher-priority arrival does not
  // displace it, and global mie does not withdraw an issued request.
  always_comb begin
    latched_elig = 1'b0;
    case (irq_cause_q[7:0])
      interrupt_mach_extern: latched_elig = meip & meie;
      interrupt_mach_soft:   latched_elig = msip & msie;
      interrupt_mach_timer:  latched_elig = mtip & mtie;
      interrupt_uart_extern: latched_elig = (irpt_p & meie) | uart_sticky;
      default:               latched_elig = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Scheduler FSM: arbitrate in IDLE, hold the request in REQ, wait for mret
  // in SERVICE, then count down the hold-off in HOLD.
  always_comb begin
    state_d     = state_q;
    irq_req_d   = irq_req_q;
    irq_cause_d = irq_cause_q;
    cnt_d       = cnt_q;
    irq_pend_d  = src_pend;

    case (state_q)
      IDLE: begin
        irq_req_d = 1'b0;
        if (eligible_any && valid) begin
          state_d     = REQ;
          irq_req_d   = 1'b1;
          irq_cause_d = irq_make_cause(enc_code);
        end
      end

      REQ: begin
        if (trap_ack) begin
          state_d   = SERVICE;
          irq_req_d = 1'b0;
        end else if (!latched_elig) begin
          state_d   = IDLE;
          irq_req_d = 1'b0;
        end
      end

      SERVICE: begin
        irq_req_d = 1'b0;
        if (mret) begin
          if (HOLDOFF == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            cnt_d   = CNT_W'(HOLDOFF);
          end
        end
      end

      HOLD: begin
        irq_req_d = 1'b0;
        // Saturating countdown; the cycle that reaches zero leaves HOLD
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        irq_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      irq_req_q   <= 1'b0;
      irq_cause_q <= 32'd0;
      irq_pend_q  <= 4'd0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      irq_req_q   <= irq_req_d;
      irq_cause_q <= irq_cause_d;
      irq_pend_q  <= irq_pend_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign irq_req   = irq_req_q;
  assign irq_cause = irq_cause_q;
  assign irq_pend  = irq_pend_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_sched.sv
// ============================================================================
//  Module   : tb_irq_sched
//  Purpose  : Directed, table-driven bench for irq_sched (HOLDOFF = 2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_irq_sched;

  localparam logic [31:0] C_EXT  = 32'h8000_000B;
  localparam logic [31:0] C_SOFT = 32'h8000_0003;
  localparam logic [31:0] C_TMR  = 32'h8000_0007;
  localparam logic [31:0] C_UART = 32'h8000_0010;

  logic        clock = 1'b0;
  logic        reset;
  logic        meip, msip, mtip, irpt;
  logic        mstatus_mie;
  logic [2:0]  mie_en;
  logic        valid, trap_ack, mret;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic [3:0]  irq_pend;
  logic        busy;

  int checks = 0;
  int errors = 0;

  irq_sched #(.HOLDOFF(2), .CNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .meip        (meip),
    .msip        (msip),
    .mtip        (mtip),
    .irpt        (irpt),
    .mstatus_mie (mstatus_mie),
    .mie_en      (mie_en),
    .valid       (valid),
    .trap_ack    (trap_ack),
    .mret        (mret),
    .irq_req     (irq_req),
    .irq_cause   (irq_cause),
    .irq_pend    (irq_pend),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // One record per clock: inputs applied before the edge, outputs after it
  typedef struct {
    logic        rst_n;
    logic [3:0]  src;      // {irpt, mtip, msip, meip}
    logic        mie;
    logic [2:0]  en;
    logic        v;
    logic        ack;
    logic        mr;
    logic        e_req;
    logic [31:0] e_cause;
    logic        chk_cause;
    logic [3:0]  e_pend;
    logic        e_busy;
  } vec_t;

  vec_t tv [0:79];
  int   nvec = 0;

  task automatic add(input logic r, input logic [3:0] s, input logic m,
                     input logic [2:0] e, input logic v, input logic a,
                     input logic mr, input logic rq, input logic [31:0] c,
                     input logic cc, input logic [3:0] p, input logic b);
    tv[nvec].rst_n     = r;
    tv[nvec].src       = s;
    tv[nvec].mie       = m;
    tv[nvec].en        = e;
    tv[nvec].v         = v;
    tv[nvec].ack       = a;
    tv[nvec].mr        = mr;
    tv[nvec].e_req     = rq;
    tv[nvec].e_cause   = c;
    tv[nvec].chk_cause = cc;
    tv[nvec].e_pend    = p;
    tv[nvec].e_busy    = b;
    nvec++;
  endtask

  initial begin
    int lat;
    logic got;

    reset = 1'b0; meip = 0; msip = 0; mtip = 0; irpt = 0;
    mstatus_mie = 0; mie_en = 3'b000; valid = 0; trap_ack = 0; mret = 0;

    //   rst src  mie en     v  a  m    req cause  cc pend busy
    // reset state, inputs active during reset are not seen
    add(0, 4'h0, 0, 3'b000, 0, 0, 0,   0, 32'h0,  1, 4'h0, 0);
    add(0, 4'h7, 1, 3'b111, 1, 0, 0,   0, 32'h0,  1, 4'h0, 0);
    // meip/msip/mtip together: meip wins, ack, mret, hold-off, re-request
    add(1, 4'h7, 1, 3'b111, 1, 0, 0,   1, C_EXT,  1, 4'h7, 1);
    add(1, 4'h7, 1, 3'b111, 0, 0, 0,   1, C_EXT,  1, 4'h7, 1);
    add(1, 4'h7, 1, 3'b111, 0, 1, 0,   0, C_EXT,  1, 4'h7, 1);
    add(1, 4'h7, 1, 3'b111, 1, 0, 0,   0, C_EXT,  1, 4'h7, 1);
    add(1, 4'h7, 1, 3'b111, 0, 0, 1,   0, C_EXT,  1, 4'h7, 1);
    add(1, 4'h7, 1, 3'b111, 1, 0, 1,   0, C_EXT,  1, 4'h7, 1);
    add(1, 4'h7, 1, 3'b111, 1, 0, 0,   0, C_EXT,  1, 4'h7, 0);
    add(1, 4'h7, 1, 3'b111, 1, 0, 0,   1, C_EXT,  1, 4'h7, 1);
    add(1, 4'h7, 1, 3'b111, 0, 1, 0,   0, C_EXT,  1, 4'h7, 1);
    add(1, 4'h0, 1, 3'b111, 0, 0, 1,   0, C_EXT,  1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b111, 0, 0, 0,   0, C_EXT,  1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b111, 0, 0, 0,   0, C_EXT,  1, 4'h0, 0);
    // mtip request, msip arriving in REQ does not change the cause
    add(1, 4'h4, 1, 3'b011, 1, 0, 0,   1, C_TMR,  1, 4'h4, 1);
    add(1, 4'h6, 1, 3'b011, 1, 0, 0,   1, C_TMR,  1, 4'h6, 1);
    add(1, 4'h6, 1, 3'b011, 0, 0, 0,   1, C_TMR,  1, 4'h6, 1);
    add(1, 4'h6, 1, 3'b011, 0, 1, 0,   0, C_TMR,  1, 4'h6, 1);
    add(1, 4'h0, 1, 3'b011, 0, 0, 1,   0, C_TMR,  1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b011, 0, 0, 0,   0, C_TMR,  1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b011, 0, 0, 0,   0, C_TMR,  1, 4'h0, 0);
    // msip withdrawn by level drop, then by enable clear
    add(1, 4'h2, 1, 3'b011, 1, 0, 0,   1, C_SOFT, 1, 4'h2, 1);
    add(1, 4'h0, 1, 3'b011, 0, 0, 0,   0, 32'h0,  0, 4'h0, 0);
    add(1, 4'h2, 1, 3'b011, 1, 0, 0,   1, C_SOFT, 1, 4'h2, 1);
    add(1, 4'h2, 1, 3'b001, 0, 0, 0,   0, 32'h0,  0, 4'h2, 0);
    // ack in the same cycle as the source drop: ack wins
    add(1, 4'h2, 1, 3'b011, 1, 0, 0,   1, C_SOFT, 1, 4'h2, 1);
    add(1, 4'h0, 1, 3'b011, 0, 1, 0,   0, C_SOFT, 1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b011, 0, 0, 1,   0, C_SOFT, 1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b011, 0, 0, 0,   0, C_SOFT, 1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b011, 0, 0, 0,   0, C_SOFT, 1, 4'h0, 0);
    // global enable and valid gating, then reset while in SERVICE
    add(1, 4'h1, 0, 3'b111, 1, 0, 0,   0, 32'h0,  0, 4'h1, 0);
    add(1, 4'h1, 1, 3'b111, 0, 0, 0,   0, 32'h0,  0, 4'h1, 0);
    add(1, 4'h1, 1, 3'b111, 1, 0, 0,   1, C_EXT,  1, 4'h1, 1);
    add(1, 4'h1, 1, 3'b111, 0, 1, 0,   0, C_EXT,  1, 4'h1, 1);
    add(0, 4'h1, 1, 3'b111, 1, 0, 0,   0, 32'h0,  1, 4'h0, 0);
    // trap_ack and mret in IDLE are ignored
    add(1, 4'h0, 1, 3'b111, 0, 1, 0,   0, 32'h0,  1, 4'h0, 0);
    add(1, 4'h0, 1, 3'b111, 0, 0, 1,   0, 32'h0,  1, 4'h0, 0);
`ifdef IRQ_SCHED_IRPT_EDGE_EN
    // 1-cycle irpt pulse with mie off stays pending, requests when enabled
    add(1, 4'h8, 0, 3'b100, 1, 0, 0,   0, 32'h0,  1, 4'h0, 0);
    add(1, 4'h0, 0, 3'b100, 1, 0, 0,   0, 32'h0,  1, 4'h8, 0);
    add(1, 4'h0, 0, 3'b100, 1, 0, 0,   0, 32'h0,  1, 4'h8, 0);
    add(1, 4'h0, 1, 3'b100, 1, 0, 0,   1, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b000, 0, 0, 0,   1, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b100, 0, 1, 0,   0, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 0,   0, C_UART, 1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 1,   0, C_UART, 1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 0,   0, C_UART, 1, 4'h0, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 0,   0, C_UART, 1, 4'h0, 0);
    // new edge in the same cycle as the clearing ack keeps irpt_p set
    add(1, 4'h8, 1, 3'b100, 1, 0, 0,   0, C_UART, 1, 4'h0, 0);
    add(1, 4'h0, 1, 3'b100, 1, 0, 0,   1, C_UART, 1, 4'h8, 1);
    add(1, 4'h8, 1, 3'b100, 0, 1, 0,   0, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 0,   0, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 1,   0, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 0,   0, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 0,   0, C_UART, 1, 4'h8, 0);
    add(1, 4'h0, 1, 3'b100, 1, 0, 0,   1, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b100, 0, 1, 0,   0, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 0,   0, C_UART, 1, 4'h0, 1);
`else
    // level irpt gated by meie, withdrawn when it drops
    add(1, 4'h8, 1, 3'b100, 1, 0, 0,   1, C_UART, 1, 4'h8, 1);
    add(1, 4'h0, 1, 3'b100, 0, 0, 0,   0, 32'h0,  0, 4'h0, 0);
`endif

    for (int i = 0; i < nvec; i++) begin
      reset       = tv[i].rst_n;
      {irpt, mtip, msip, meip} = tv[i].src;
      mstatus_mie = tv[i].mie;
      mie_en      = tv[i].en;
      valid       = tv[i].v;
      trap_ack    = tv[i].ack;
      mret        = tv[i].mr;
      @(posedge clock);
      #1;
      checks++;
      if (irq_req !== tv[i].e_req) begin
        errors++;
        $display("FAIL vec%0d irq_req got %b want %b", i, irq_req, tv[i].e_req);
      end
      checks++;
      if (busy !== tv[i].e_busy) begin
        errors++;
        $display("FAIL vec%0d busy got %b want %b", i, busy, tv[i].e_busy);
      end
      checks++;
      if (irq_pend !== tv[i].e_pend) begin
        errors++;
        $display("FAIL vec%0d irq_pend got %h want %h", i, irq_pend, tv[i].e_pend);
      end
      if (tv[i].chk_cause) begin
        checks++;
        if (irq_cause !== tv[i].e_cause) begin
          errors++;
          $display("FAIL vec%0d irq_cause got %h want %h", i, irq_cause, tv[i].e_cause);
        end
      end
    end

    // Request latency from reset-idle: exactly one cycle after decision edge
    reset = 1'b0; {irpt, mtip, msip, meip} = 4'h0; valid = 0;
    trap_ack = 0; mret = 0;
    @(posedge clock);
    #1;
    reset = 1'b1; meip = 1'b1; mstatus_mie = 1'b1; mie_en = 3'b111; valid = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!got) begin
        @(posedge clock);
        #1;
        if (irq_req === 1'b1) begin
          got = 1'b1;
          lat = k;
        end
      end
    end
    checks++;
    if (!got || lat != 1) begin
      errors++;
      $display("FAIL latency got %0d cycles (seen=%b) want 1", lat, got);
    end
    checks++;
    if (irq_cause !== C_EXT) begin
      errors++;
      $display("FAIL latency_cause got %h want %h", irq_cause, C_EXT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
